// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state, control bundle and helpers for pipe_stall_ctrl
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic back_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Unfrozen-cycle controls; load-use beats branch because the branch operand is stale.
  function automatic ctrl_t run_ctrl(input logic hazard, input logic branch);
    ctrl_t c;
    c = CTRL_IDLE;
    if (hazard) begin
      c.idex_bubble = 1'b1;
      c.back_en     = 1'b1;
    end else begin
      c.pc_we      = 1'b1;
      c.ifid_we    = 1'b1;
      c.ifid_flush = branch;
      c.back_en    = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_perf.sv
// rtl/pipe_stall_perf.sv - wrapping counters for bubbles, flushes and frozen cycles
module pipe_stall_perf
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             active_i,
  input  logic             bubble_i,
  input  logic             flush_i,
  input  logic             frozen_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      memwait_cnt_o <= '0;
    end else if (active_i) begin
      if (bubble_i) stall_cnt_o   <= stall_cnt_o + 1'b1;
      if (flush_i)  flush_cnt_o   <= flush_cnt_o + 1'b1;
      if (frozen_i) memwait_cnt_o <= memwait_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer; PIPE_STALL_PERF_EN adds perf counters
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int WAIT_W      = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_stall_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             back_en_o,
  output logic             busy_o,
`ifdef PIPE_STALL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o,
`endif
  output logic             err_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;

  state_t            state, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  ctrl_t             ctrl;
  logic              mem_stall;
  logic              active;

  assign mem_stall = dmem_req_i & ~dmem_ack_i;
  assign active    = (state == ST_RUN) || (state == ST_MEM_WAIT);

  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    ctrl    = CTRL_IDLE;
    case (state)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          ctrl = run_ctrl(hazard_stall_i, branch_taken_i);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt == TIMEOUT_CNT) state_d = ST_ERROR;
          else if (wait_cnt != WAIT_MAX) wait_d = wait_cnt + 1'b1;
        end else begin
          // The release cycle is already unfrozen and follows RUN rules.
          state_d = ST_RUN;
          wait_d  = '0;
          ctrl    = run_ctrl(hazard_stall_i, branch_taken_i);
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      busy_o   <= (state_d == ST_RUN) || (state_d == ST_MEM_WAIT);
      err_o    <= (state_d == ST_ERROR);
    end
  end

  assign pc_we_o       = ctrl.pc_we;
  assign ifid_we_o     = ctrl.ifid_we;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_bubble_o = ctrl.idex_bubble;
  assign back_en_o     = ctrl.back_en;

`ifdef PIPE_STALL_PERF_EN
  pipe_stall_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .active_i     (active),
    .bubble_i     (ctrl.idex_bubble),
    .flush_i      (ctrl.ifid_flush),
    .frozen_i     (active & mem_stall),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o),
    .memwait_cnt_o(memwait_cnt_o)
  );
`else
  logic unused_active;
  assign unused_active = active;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl with a behavioural model
module tb_pipe_stall_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0, hazard_stall_i = 1'b0, branch_taken_i = 1'b0;
  logic dmem_req_i = 1'b0, dmem_ack_i = 1'b0;
  logic pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_en_o, busy_o, err_o;
`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MEM_TIMEOUT(TMO), .WAIT_W(8), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .hazard_stall_i(hazard_stall_i),
    .branch_taken_i(branch_taken_i),
    .dmem_req_i    (dmem_req_i),
    .dmem_ack_i    (dmem_ack_i),
    .pc_we_o       (pc_we_o),
    .ifid_we_o     (ifid_we_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_bubble_o (idex_bubble_o),
    .back_en_o     (back_en_o),
    .busy_o        (busy_o),
`ifdef PIPE_STALL_PERF_EN
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
    .memwait_cnt_o (memwait_cnt_o),
`endif
    .err_o         (err_o)
  );

  // Model: running/halted flags and how many cycles have been spent waiting on memory.
  bit m_run, m_err;
  int m_wait;
  longint m_stall_n, m_flush_n, m_mw_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] exp_q[$];   // {busy, err, pc_we, ifid_we, flush, bubble, back_en}
  int         cyc_q[$];
  longint     perf_q[$];

  task automatic model_reset();
    m_run = 0; m_err = 0; m_wait = 0;
    m_stall_n = 0; m_flush_n = 0; m_mw_n = 0;
  endtask

  task automatic step(input bit rst_n, input bit st, input bit hz, input bit br,
                      input bit rq, input bit ak);
    bit stall;
    logic [4:0] c;
    @(posedge clk);
    #1;
    cyc++;
    rst_i = rst_n; start_i = st; hazard_stall_i = hz; branch_taken_i = br;
    dmem_req_i = rq; dmem_ack_i = ak;
    if (!rst_n) model_reset();
    stall = rq && !ak;
    if (!m_run || stall)  c = 5'b00000;
    else if (hz)          c = 5'b00011;
    else                  c = {1'b1, 1'b1, br, 1'b0, 1'b1};
    exp_q.push_back({m_run, m_err, c});
    cyc_q.push_back(cyc);
    perf_q.push_back(m_stall_n); perf_q.push_back(m_flush_n); perf_q.push_back(m_mw_n);
    if (rst_n) begin
      if (m_run) begin
        if (stall) m_mw_n++;
        else if (hz) m_stall_n++;
        else if (br) m_flush_n++;
        if (!stall) m_wait = 0;
        else if (m_wait == TMO) begin m_run = 0; m_err = 1; end
        else m_wait++;
      end else if (!m_err && st) begin
        m_run = 1;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents a control set; compare it mid-cycle.
  initial begin
    logic [6:0] e, a;
    int         c;
    longint     ps, pf, pm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        ps = perf_q.pop_front(); pf = perf_q.pop_front(); pm = perf_q.pop_front();
        a = {busy_o, err_o, pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_en_o};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl cycle %0d: got %b expected %b", c, a, e);
        end
`ifdef PIPE_STALL_PERF_EN
        checks++;
        if (stall_cnt_o !== CNT_W'(ps) || flush_cnt_o !== CNT_W'(pf) ||
            memwait_cnt_o !== CNT_W'(pm)) begin
          errors++;
          $display("FAIL perf cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                   stall_cnt_o, flush_cnt_o, memwait_cnt_o, ps, pf, pm);
        end
`else
        if (ps < 0 || pf < 0 || pm < 0) $display("negative model count");
`endif
      end
    end
  end

  initial begin
    int burst;
    bit rq, ak;
    model_reset();
    // Reset, then idle with start low.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Single load-use, load-use with branch, then branch alone.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    // Three frozen cycles then ack with a pending hazard.
    repeat (3) step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    // Hung memory reaches ERROR; start is ignored there.
    repeat (8) step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // Reset in the middle of a memory wait.
    repeat (2) step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // Randomized traffic with occasional long memory stalls and resets.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        rq = 1; ak = 0; burst--;
      end else begin
        rq = ($urandom % 3) == 0;
        ak = ($urandom % 2) == 0;
        if (($urandom % 15) == 0) burst = $urandom_range(1, 7);
      end
      step(($urandom % 80) != 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
           ($urandom % 5) == 0, rq, ak);
    end
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It merges three hazard sources into one consistent set of pipeline-register controls:
- load-use stall from the hazard detection unit
- branch-taken flush from ID
- multi-cycle data-memory wait from MEM

It also gates pipeline start-up and traps a hung memory with a timeout. Sits beside the hazard detection unit; drives PC, IF/ID, ID/EX and the downstream stage registers.

Parameters:
MEM_TIMEOUT, 64, max consecutive cycles MEM may wait for dmem_ack_i before error (range 1..2^WAIT_W-1)
WAIT_W, 8, width of the memory-wait counter
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  level; pipeline begins execution when sampled high in IDLE
hazard_stall_i  in  1  load-use stall request from hazard detection unit
branch_taken_i  in  1  branch resolved taken in ID this cycle
dmem_req_i  in  1  MEM stage holds a load/store this cycle
dmem_ack_i  in  1  data memory completes the MEM-stage access this cycle
pc_we_o  out  1  PC write enable
ifid_we_o  out  1  IF/ID register write enable
ifid_flush_o  out  1  IF/ID register loads a NOP
idex_bubble_o  out  1  ID/EX control fields zeroed (NOP inserted)
back_en_o  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
busy_o  out  1  registered; 1 in RUN or MEM_WAIT
err_o  out  1  registered; 1 in ERROR

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, wait_cnt=0, busy_o=0, err_o=0. All control outputs 0 while in IDLE.
- States: IDLE, RUN, MEM_WAIT, ERROR.
- IDLE -> RUN: on the edge where start_i=1. First enabled cycle is the cycle after.
- Memory freeze: mem_stall = dmem_req_i & ~dmem_ack_i.
  - Evaluated combinationally in RUN and MEM_WAIT.
  - When 1: pc_we_o=0, ifid_we_o=0, back_en_o=0, ifid_flush_o=0, idex_bubble_o=0.
  - Memory freeze has top priority; hazard and branch are held and re-evaluated after release.
- RUN -> MEM_WAIT: on an edge with mem_stall=1. wait_cnt loads 1.
- MEM_WAIT:
  - mem_stall=1: wait_cnt increments (saturates at 2^WAIT_W-1).
  - If wait_cnt==MEM_TIMEOUT with mem_stall still 1 -> ERROR.
  - dmem_ack_i=1 or dmem_req_i=0: release to RUN; wait_cnt clears.
  - The ack cycle itself is unfrozen, so outputs follow RUN rules that cycle.
- Load-use (RUN-rule cycle, hazard_stall_i=1): pc_we_o=0, ifid_we_o=0, idex_bubble_o=1, back_en_o=1, ifid_flush_o=0.
- Branch (RUN-rule cycle, branch_taken_i=1, hazard_stall_i=0): pc_we_o=1, ifid_we_o=1, ifid_flush_o=1, back_en_o=1.
- Load-use and branch in the same cycle: load-use wins and no flush is issued. The branch operand is stale; the branch re-resolves next cycle.
- Otherwise in RUN: pc_we_o=ifid_we_o=back_en_o=1, flush=bubble=0.
- ERROR: all control outputs 0, err_o=1. Only reset exits.
- start_i is ignored outside IDLE.
- Reset mid-MEM_WAIT: immediate return to IDLE, counters cleared.
- busy_o and err_o reflect the registered state, so they change the cycle after the transition.
- Latency: controls are combinational from state+inputs (zero-cycle); only state and counters are registered.

Optional Feature:
Macro PIPE_STALL_PERF_EN.
- Defined: add outputs stall_cnt_o[CNT_W] (load-use bubbles issued), flush_cnt_o[CNT_W] (IF/ID flushes issued) and memwait_cnt_o[CNT_W] (frozen cycles).
  - All three count only in RUN/MEM_WAIT and wrap modulo 2^CNT_W.
  - Reset to 0 asynchronously.
  - Each increments on the same edge as the event's cycle.
- Undefined: ports and logic absent; remaining behaviour identical.

Decomposition:
- Shared pipeline package: state enum (IDLE, RUN, MEM_WAIT, ERROR), a control-bundle struct (pc_we, ifid_we, ifid_flush, idex_bubble, back_en) and the default-idle bundle constant.
- One natural sub-module, pipe_stall_perf: the counter bank, instantiated only under PIPE_STALL_PERF_EN.

Test Plan:
- Reset with rst_i low, then release with start_i=0 for 5 cycles -> all controls 0, busy_o=0. Raise start_i -> next cycle pc_we_o=1, busy_o=1.
- In RUN, hazard_stall_i=1 for one cycle -> pc_we_o=0, ifid_we_o=0, idex_bubble_o=1 that cycle only. Perf: stall_cnt_o=1.
- hazard_stall_i=1 and branch_taken_i=1 together -> no ifid_flush_o, bubble=1. Next cycle branch_taken_i=1 alone -> ifid_flush_o=1.
- dmem_req_i=1, dmem_ack_i=0 for 3 cycles, then ack -> back_en_o=0 for 3 cycles, unfrozen on ack cycle. Perf: memwait_cnt_o=3.
- MEM_TIMEOUT=4, ack never given -> after the 4th wait-cycle edge err_o=1, all controls 0. Asserting start_i has no effect; only rst_i low recovers.
- Assert rst_i low during MEM_WAIT -> outputs 0 immediately, state IDLE, counters 0.
